corefifo_rd_ptr_ctrl: RTL and testbench

Read-domain pointer and status controller for the async FIFO. It synchronizes the Gray-coded write pointer into the read clock domain and converts it to binary. It maintains the read pointer in binary and Gray form and produces registered empty, almost-empty, underflow and fill-level outputs. It drives the RAM read address and sends its Gray read pointer back to the write domain.

---
 rtl/corefifo_rd_ptr_ctrl_if.sv | 25 ++
 rtl/corefifo_rd_ptr_ctrl.sv | 93 +++++++++
 tb/tb_corefifo_rd_ptr_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/corefifo_rd_ptr_ctrl_if.sv
// Read-side signal bundle for corefifo_rd_ptr_ctrl: read request, incoming Gray
// write pointer, RAM address, Gray read pointer and status flags.
interface corefifo_rd_ptr_ctrl_if #(
   parameter int ADDRWIDTH = 3
);
   logic                 re;
   logic [ADDRWIDTH:0]   wptr_gray;
   logic [ADDRWIDTH-1:0] raddr;
   logic [ADDRWIDTH:0]   rptr_gray;
   logic                 empty;
   logic                 aempty;
   logic                 rd_valid;
   logic                 underflow;
   logic [ADDRWIDTH:0]   rdcnt;

   modport master (
      output re, wptr_gray,
      input  raddr, rptr_gray, empty, aempty, rd_valid, underflow, rdcnt
   );

   modport slave (
      input  re, wptr_gray,
      output raddr, rptr_gray, empty, aempty, rd_valid, underflow, rdcnt
   );
endinterface

// File: rtl/corefifo_rd_ptr_ctrl.sv
// Read-domain pointer/status controller for the async FIFO.
// Optional macro RDCNT_EN enables the registered fill-level output rdcnt.
module corefifo_rd_ptr_ctrl #(
   parameter int ADDRWIDTH     = 3,
   parameter int SYNC_STAGES   = 2,
   parameter int AEMPTY_THRESH = 2
) (
   input logic                   rclock,
   input logic                   reset,
   corefifo_rd_ptr_ctrl_if.slave bus
);
   localparam int            PW        = ADDRWIDTH + 1;
   localparam logic [PW-1:0] AE_THRESH = PW'(AEMPTY_THRESH);

   logic [PW-1:0] r_sync [SYNC_STAGES];
   logic [PW-1:0] r_rptr_bin;
   logic [PW-1:0] r_rptr_gray;
   logic          r_empty;
   logic          r_aempty;
   logic          r_rd_valid;
   logic          r_underflow;

   logic [PW-1:0] w_wsync;
   logic [PW-1:0] w_wbin;
   logic [PW-1:0] w_rptr_bin_next;
   logic [PW-1:0] w_rptr_gray_next;
   logic [PW-1:0] w_lvl_next;
   logic          w_rd_ok;

   function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
      logic [PW-1:0] b;
      b[PW-1] = g[PW-1];
      for (int i = PW - 1; i > 0; i--) b[i-1] = b[i] ^ g[i-1];
      return b;
   endfunction

   // Only the Gray pointer crosses into rclock; binary is derived after the chain.
   always_ff @(posedge rclock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
      end else begin
         r_sync[0] <= bus.wptr_gray;
         for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
      end
   end

   assign w_wsync          = r_sync[SYNC_STAGES-1];
   assign w_wbin           = gray2bin(w_wsync);
   assign w_rd_ok          = bus.re & ~r_empty;
   assign w_rptr_bin_next  = r_rptr_bin + PW'(w_rd_ok);
   assign w_rptr_gray_next = w_rptr_bin_next ^ (w_rptr_bin_next >> 1);
   assign w_lvl_next       = w_wbin - w_rptr_bin_next;

   // Flags use the next read pointer against the current wsync, so a last-word
   // read coinciding with a newly synchronized write leaves empty low.
   always_ff @(posedge rclock or posedge reset) begin
      if (reset) begin
         r_rptr_bin  <= '0;
         r_rptr_gray <= '0;
         r_empty     <= 1'b1;
         r_aempty    <= 1'b1;
         r_rd_valid  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         r_rptr_bin  <= w_rptr_bin_next;
         r_rptr_gray <= w_rptr_gray_next;
         r_empty     <= (w_rptr_gray_next == w_wsync);
         r_aempty    <= (w_lvl_next <= AE_THRESH);
         r_rd_valid  <= w_rd_ok;
         r_underflow <= bus.re & r_empty;
      end
   end

`ifdef RDCNT_EN
   logic [PW-1:0] r_rdcnt;

   always_ff @(posedge rclock or posedge reset) begin
      if (reset) r_rdcnt <= '0;
      else       r_rdcnt <= w_lvl_next;
   end

   assign bus.rdcnt = r_rdcnt;
`else
   assign bus.rdcnt = '0;
`endif

   assign bus.raddr     = r_rptr_bin[ADDRWIDTH-1:0];
   assign bus.rptr_gray = r_rptr_gray;
   assign bus.empty     = r_empty;
   assign bus.aempty    = r_aempty;
   assign bus.rd_valid  = r_rd_valid;
   assign bus.underflow = r_underflow;
endmodule

// File: tb/tb_corefifo_rd_ptr_ctrl.sv
// Self-checking bench for corefifo_rd_ptr_ctrl: a count-based reference model
// pushes expected outputs per cycle; each test pops and compares after the edge.
`timescale 1ns/1ps
module tb_corefifo_rd_ptr_ctrl;
   localparam int AW   = 3;
   localparam int PW   = AW + 1;
   localparam int MASK = (1 << PW) - 1;

   typedef struct packed {
      logic          empty;
      logic          aempty;
      logic          rd_valid;
      logic          underflow;
      logic [PW-1:0] rdcnt;
      logic [PW-1:0] rptr_gray;
      logic [AW-1:0] raddr;
   } out_t;

   logic rclock = 1'b0;
   logic reset;

   corefifo_rd_ptr_ctrl_if #(.ADDRWIDTH(AW)) bus ();

   corefifo_rd_ptr_ctrl #(
      .ADDRWIDTH    (AW),
      .SYNC_STAGES  (2),
      .AEMPTY_THRESH(2)
   ) dut (
      .rclock(rclock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 rclock = ~rclock;

   int   n_checks = 0;
   int   n_fail   = 0;
   out_t exp_q[$];

   // Model state: true write count, two synchronizer stages, read count.
   int   m_w, m_s1, m_s2, m_rc;
   logic m_empty;

   function automatic logic [PW-1:0] to_gray(input int v);
      logic [PW-1:0] b;
      b = PW'(v);
      return b ^ (b >> 1);
   endfunction

   function automatic out_t model(input int s, input int rc, input logic rdv, input logic unf);
      out_t o;
      int   lvl;
      lvl         = (s - rc) & MASK;
      o.empty     = (lvl == 0);
      o.aempty    = (lvl <= 2);
      o.rd_valid  = rdv;
      o.underflow = unf;
`ifdef RDCNT_EN
      o.rdcnt     = PW'(lvl);
`else
      o.rdcnt     = '0;
`endif
      o.rptr_gray = to_gray(rc);
      o.raddr     = AW'(rc);
      return o;
   endfunction

   function automatic out_t observe();
      out_t o;
      o.empty     = bus.empty;
      o.aempty    = bus.aempty;
      o.rd_valid  = bus.rd_valid;
      o.underflow = bus.underflow;
      o.rdcnt     = bus.rdcnt;
      o.rptr_gray = bus.rptr_gray;
      o.raddr     = bus.raddr;
      return o;
   endfunction

   function automatic out_t reset_vals();
      out_t o;
      o           = '0;
      o.empty     = 1'b1;
      o.aempty    = 1'b1;
      return o;
   endfunction

   task automatic drive_cycle(input logic re_v);
      logic ok;
      bus.re        = re_v;
      bus.wptr_gray = to_gray(m_w);
      ok            = re_v & ~m_empty;
      m_rc          = (m_rc + (ok ? 1 : 0)) & MASK;
      exp_q.push_back(model(m_s2, m_rc, ok, re_v & m_empty));
      m_empty       = (((m_s2 - m_rc) & MASK) == 0);
      m_s2          = m_s1;
      m_s1          = m_w;
      @(posedge rclock);
      #1;
   endtask

   task automatic model_reset();
      m_w = 0; m_s1 = 0; m_s2 = 0; m_rc = 0; m_empty = 1'b1;
      exp_q.delete();
   endtask

   task automatic do_reset();
      bus.re        = 1'b0;
      bus.wptr_gray = '0;
      reset         = 1'b1;
      model_reset();
      #12;
      reset = 1'b0;
      @(posedge rclock);
      #1;
   endtask

   task automatic test_reset();
      out_t o, e;
      do_reset();
      m_w = 6;
      for (int k = 0; k < 8; k++) begin
         drive_cycle(k >= 3);
         o = observe(); e = exp_q.pop_front(); n_checks++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL reset_pre cyc%0d: got %h expected %h", k, o, e);
         end
      end
      #2;
      reset = 1'b1;
      #1;
      o = observe(); n_checks++;
      if (o !== reset_vals()) begin
         n_fail++;
         $display("FAIL reset_async: got %h expected %h", o, reset_vals());
      end
      bus.re = 1'b0; bus.wptr_gray = '0;
      #10;
      reset = 1'b0;
      #1;
      o = observe(); n_checks++;
      if (o !== reset_vals()) begin
         n_fail++;
         $display("FAIL reset_hold: got %h expected %h", o, reset_vals());
      end
      model_reset();
      drive_cycle(1'b0);
      o = observe(); e = exp_q.pop_front(); n_checks++;
      if (o !== e) begin
         n_fail++;
         $display("FAIL reset_post: got %h expected %h", o, e);
      end
   endtask

   task automatic test_sync_latency();
      out_t o, e;
      int   fall_edge;
      do_reset();
      m_w = 1;
      fall_edge = -1;
      for (int k = 1; k <= 5; k++) begin
         drive_cycle(1'b0);
         o = observe(); e = exp_q.pop_front(); n_checks++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL sync_latency edge%0d: got %h expected %h", k, o, e);
         end
         if (!o.empty && fall_edge < 0) fall_edge = k;
      end
      n_checks++;
      if (fall_edge !== 3) begin
         n_fail++;
         $display("FAIL sync_latency_edge: got %0d expected 3", fall_edge);
      end
   endtask

   task automatic test_fill_drain();
      out_t o, e;
      int   nv;
      do_reset();
      m_w = 8;
      nv  = 0;
      for (int k = 0; k < 13; k++) begin
         drive_cycle(k >= 3 && k < 11);
         o = observe(); e = exp_q.pop_front(); n_checks++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL fill_drain cyc%0d: got %h expected %h", k, o, e);
         end
         if (o.rd_valid) nv++;
      end
      n_checks++;
      if (nv !== 8) begin
         n_fail++;
         $display("FAIL fill_drain_rd_valid_count: got %0d expected 8", nv);
      end
   endtask

   task automatic test_underflow();
      out_t o, e;
      int   nu;
      do_reset();
      nu = 0;
      for (int k = 0; k < 4; k++) begin
         drive_cycle(k < 3);
         o = observe(); e = exp_q.pop_front(); n_checks++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL underflow cyc%0d: got %h expected %h", k, o, e);
         end
         if (o.underflow) nu++;
      end
      n_checks++;
      if (nu !== 3) begin
         n_fail++;
         $display("FAIL underflow_count: got %0d expected 3", nu);
      end
   endtask

   task automatic test_wrap();
      out_t          o, e;
      logic [PW-1:0] prev;
      do_reset();
      m_w = 15;
      for (int k = 0; k < 18; k++) begin
         drive_cycle(k >= 3);
         o = observe(); e = exp_q.pop_front(); n_checks++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL wrap_preset cyc%0d: got %h expected %h", k, o, e);
         end
      end
      m_w  = 1;
      prev = bus.rptr_gray;
      for (int k = 0; k < 6; k++) begin
         drive_cycle(k == 3 || k == 4);
         o = observe(); e = exp_q.pop_front(); n_checks++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL wrap cyc%0d: got %h expected %h", k, o, e);
         end
         if (k == 3 || k == 4) begin
            n_checks++;
            if ($countones(prev ^ o.rptr_gray) !== 1) begin
               n_fail++;
               $display("FAIL wrap_gray_onebit cyc%0d: got %b after %b expected one bit change",
                        k, o.rptr_gray, prev);
            end
         end
         prev = o.rptr_gray;
      end
   endtask

   task automatic test_back_to_back_simul();
      out_t o, e;
      do_reset();
      m_w = 1;
      for (int k = 0; k < 3; k++) begin
         drive_cycle(1'b0);
         o = observe(); e = exp_q.pop_front(); n_checks++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL simul_setup cyc%0d: got %h expected %h", k, o, e);
         end
      end
      m_w = 2;
      for (int k = 0; k < 5; k++) begin
         drive_cycle(k == 2);
         o = observe(); e = exp_q.pop_front(); n_checks++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL simul cyc%0d: got %h expected %h", k, o, e);
         end
         if (k == 2) begin
            n_checks++;
            if (o.empty !== 1'b0 || o.underflow !== 1'b0 || o.rd_valid !== 1'b1) begin
               n_fail++;
               $display("FAIL simul_last_word: got empty=%b underflow=%b rd_valid=%b expected 0 0 1",
                        o.empty, o.underflow, o.rd_valid);
            end
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_sync_latency();
      test_fill_drain();
      test_underflow();
      test_wrap();
      test_back_to_back_simul();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
